// File: rtl/seq_table_ctrl.sv
// seq_table_ctrl: programmable code-table sequencer.
// Plays table entries one per adv strobe, one-shot or looping.
module seq_table_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             len_we,
    input  logic [AW:0]      len_data,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             adv,
    output logic [WIDTH-1:0] seq_out,
    output logic             seq_valid,
    output logic [AW-1:0]    cur_idx,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             cfg_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] tbl [DEPTH];
    logic [AW:0]      len;
    logic [AW:0]      last;
    logic             at_end;
    logic             len_ok;

    logic [AW-1:0]    idx_n;
    logic [WIDTH-1:0] out_n;
    logic             valid_n;
    logic             done_n;
    logic             wrap_n;
    logic             err_n;
    logic             tbl_wr;
    logic             len_wr;

    // Reset contents reproduce the legacy fixed 0,2,5,8,11,14 counter.
    function automatic logic [WIDTH-1:0] dflt(input int i);
        case (i)
            1:       return WIDTH'(2);
            2:       return WIDTH'(5);
            3:       return WIDTH'(8);
            4:       return WIDTH'(11);
            5:       return WIDTH'(14);
            default: return '0;
        endcase
    endfunction

    assign last   = len - (AW+1)'(1);
    assign at_end = ({1'b0, cur_idx} >= last);
    assign len_ok = (len_data != '0) &&
                    (len_data <= (AW+1)'(DEPTH));
    assign busy   = (state == RUN);

    always_comb begin
        state_n = state;
        idx_n   = cur_idx;
        out_n   = seq_out;
        valid_n = seq_valid;
        done_n  = 1'b0;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        tbl_wr  = 1'b0;
        len_wr  = 1'b0;
        unique case (state)
            IDLE: begin
                tbl_wr = cfg_we;
                if (len_we) begin
                    if (len_ok) begin
                        len_wr = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                if (start && !stop) begin
                    state_n = RUN;
                    idx_n   = '0;
                    out_n   = tbl[0];
                    valid_n = 1'b1;
                end
            end
            RUN: begin
                err_n = cfg_we || len_we;
                if (stop) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (adv) begin
                    if (!at_end) begin
                        idx_n = cur_idx + AW'(1);
                        out_n = tbl[cur_idx + AW'(1)];
                    end else if (loop) begin
                        idx_n  = '0;
                        out_n  = tbl[0];
                        wrap_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_idx   <= '0;
            seq_out   <= '0;
            seq_valid <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cur_idx   <= idx_n;
            seq_out   <= out_n;
            seq_valid <= valid_n;
            done      <= done_n;
            wrap      <= wrap_n;
            cfg_err   <= err_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= dflt(i);
            end
            len <= (AW+1)'(6);
        end else begin
            if (tbl_wr) begin
                tbl[cfg_addr] <= cfg_data;
            end
            if (len_wr) begin
                len <= len_data;
            end
        end
    end

endmodule

// File: tb/tb_seq_table_ctrl.sv
// Self-checking bench for seq_table_ctrl.
// Directed scenarios plus random traffic against a sequence-level model.
module tb_seq_table_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       len_we = 1'b0;
    logic [3:0] len_data = '0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       adv = 1'b0;
    logic [3:0] seq_out;
    logic       seq_valid;
    logic [2:0] cur_idx;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    int m_tbl [8];
    int m_len;
    bit m_run;
    int m_pos;
    int m_out;
    bit m_valid;
    bit m_done;
    bit m_wrap;
    bit m_err;

    seq_table_ctrl #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .len_we    (len_we),
        .len_data  (len_data),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .adv       (adv),
        .seq_out   (seq_out),
        .seq_valid (seq_valid),
        .cur_idx   (cur_idx),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tbl   = '{0, 2, 5, 8, 11, 14, 0, 0};
        m_len   = 6;
        m_run   = 0;
        m_pos   = 0;
        m_out   = 0;
        m_valid = 0;
        m_done  = 0;
        m_wrap  = 0;
        m_err   = 0;
    endtask

    // Position-in-sequence model evaluated on the inputs of the coming edge.
    task automatic model_step();
        int first;
        first  = m_tbl[0];
        m_done = 0;
        m_wrap = 0;
        m_err  = 0;
        if (!m_run) begin
            if (cfg_we) m_tbl[cfg_addr] = cfg_data;
            if (len_we) begin
                if (len_data >= 1 && len_data <= 8) m_len = len_data;
                else m_err = 1;
            end
            if (start && !stop) begin
                m_run   = 1;
                m_pos   = 0;
                m_out   = first;
                m_valid = 1;
            end
        end else begin
            m_err = cfg_we || len_we;
            if (stop) begin
                m_run   = 0;
                m_valid = 0;
            end else if (adv) begin
                if (m_pos + 1 < m_len) begin
                    m_pos = m_pos + 1;
                    m_out = m_tbl[m_pos];
                end else if (loop) begin
                    m_pos  = 0;
                    m_out  = m_tbl[0];
                    m_wrap = 1;
                end else begin
                    m_run   = 0;
                    m_valid = 0;
                    m_done  = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("seq_out", seq_out, m_out);
        chk("seq_valid", seq_valid, m_valid);
        chk("cur_idx", cur_idx, m_pos);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("wrap", wrap, m_wrap);
        chk("cfg_err", cfg_err, m_err);
    endtask

    task automatic cyc(input bit we, input int a, input int d,
                       input bit lwe, input int ld, input bit lp,
                       input bit st, input bit sp, input bit ad);
        cfg_we   = we;
        cfg_addr = 3'(a);
        cfg_data = 4'(d);
        len_we   = lwe;
        len_data = 4'(ld);
        loop     = lp;
        start    = st;
        stop     = sp;
        adv      = ad;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input bit lp);
        cyc(0, 0, 0, 0, 0, lp, 1, 0, 0);
    endtask

    task automatic step(input bit lp);
        cyc(0, 0, 0, 0, 0, lp, 0, 0, 1);
    endtask

    initial begin
        int exp_def [6];
        int exp_rp [3];
        int wc;
        int dc;
        exp_def = '{0, 2, 5, 8, 11, 14};
        exp_rp  = '{3, 9, 15};
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        idle();

        // default one-shot sequence
        go(0);
        chk("def_code0", seq_out, exp_def[0]);
        for (int i = 1; i < 6; i++) begin
            step(0);
            chk("def_code", seq_out, exp_def[i]);
        end
        step(0);
        chk("def_done", done, 1);
        chk("def_hold", seq_out, 14);
        chk("def_valid", seq_valid, 0);
        idle();
        chk("def_done_pulse", done, 0);

        // looping run
        wc = 0;
        dc = 0;
        go(1);
        for (int i = 0; i < 13; i++) begin
            step(1);
            wc += int'(wrap);
            dc += int'(done);
        end
        chk("loop_wraps", wc, 2);
        chk("loop_dones", dc, 0);
        chk("loop_last", seq_out, 2);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0);
        idle();

        // stop beats adv and start
        go(0);
        step(0);
        step(0);
        chk("stop_pre", seq_out, 5);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("stop_busy", busy, 0);
        chk("stop_out", seq_out, 5);
        chk("stop_done", done, 0);
        idle();

        // async reset between edges
        go(0);
        step(0);
        step(0);
        step(0);
        chk("rst_pre", seq_out, 8);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        idle();
        go(0);
        for (int i = 1; i < 3; i++) begin
            step(0);
            chk("rst_seq", seq_out, exp_def[i]);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // reprogram: 3,9,15 with length 3
        cyc(1, 0, 3, 1, 3, 0, 0, 0, 0);
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 0);
        cyc(1, 2, 15, 0, 0, 0, 0, 0, 0);
        go(0);
        chk("rp_code0", seq_out, exp_rp[0]);
        for (int i = 1; i < 3; i++) begin
            step(0);
            chk("rp_code", seq_out, exp_rp[i]);
        end
        step(0);
        chk("rp_done", done, 1);

        // rejected config writes
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("err_len0", cfg_err, 1);
        cyc(0, 0, 0, 1, 9, 0, 0, 0, 0);
        chk("err_len9", cfg_err, 1);
        idle();
        chk("err_pulse", cfg_err, 0);
        go(0);
        cyc(1, 0, 7, 0, 0, 0, 0, 0, 0);
        chk("err_run", cfg_err, 1);
        chk("err_run_out", seq_out, 3);
        step(0);
        step(0);
        chk("err_keep", seq_out, 15);
        step(0);
        chk("err_len_kept", done, 1);
        go(0);
        chk("err_tbl_kept", seq_out, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit we;
            bit st;
            st = ($urandom % 4) == 0;
            we = !st && (($urandom % 6) == 0);
            cyc(we, int'($urandom % 8), int'($urandom % 16),
                ($urandom % 10) == 0, int'($urandom % 16),
                1'($urandom % 2), st, ($urandom % 16) == 0,
                1'($urandom % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_table_ctrl.md
Name: seq_table_ctrl

Overview:
Programmable sequence controller for the team's specific-sequence counters. It holds a small writable table of output codes and a length register. On start it steps through the table one entry per advance strobe, in one-shot or looping mode, with stop, done and wrap signalling. Reset contents reproduce the fixed 0,2,5,8,11,14 sequence, so it drops in where a hard-coded sequence counter sat.

Parameters:
WIDTH, 4, bit width of each table entry and of seq_out
DEPTH, 8, number of table entries (power of two, >= 6)
AW, 3, table address width, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  AW  table write address
cfg_data  input  WIDTH  table write data
len_we  input  1  length register write strobe
len_data  input  AW+1  new sequence length; legal range 1..DEPTH
loop  input  1  1 = wrap to entry 0 after the last entry; 0 = one-shot; sampled on each advance
start  input  1  begin a sequence, level-sampled
stop  input  1  abort a running sequence
adv  input  1  advance one entry (step tick)
seq_out  output  WIDTH  current sequence code (registered)
seq_valid  output  1  seq_out is part of an active sequence
cur_idx  output  AW  current table index
busy  output  1  state == RUN
done  output  1  one-cycle pulse when a one-shot sequence completes
wrap  output  1  one-cycle pulse when a looping sequence returns to entry 0
cfg_err  output  1  one-cycle pulse on a rejected config write

Behaviour:
- Reset (rst_n low, asynchronous):
  - table = {0,2,5,8,11,14,0,0} (entries >= 6 cleared); len = 6; state = IDLE.
  - seq_out = 0, seq_valid = 0, cur_idx = 0, busy = 0, done = 0, wrap = 0, cfg_err = 0.
- FSM has two states, IDLE and RUN. All outputs are registered.
- IDLE, start = 1 and stop = 0:
  - Next cycle: state RUN, cur_idx = 0, seq_out = table[0], seq_valid = 1, busy = 1.
  - Latency from start to first code is 1 clock.
- IDLE, adv = 1: ignored.
- RUN, stop = 1:
  - Next cycle: IDLE, seq_valid = 0, busy = 0; seq_out holds its value; no done.
  - stop has priority over adv and start in the same cycle.
- RUN, adv = 1, stop = 0:
  - If cur_idx < len-1: cur_idx + 1, seq_out = table[cur_idx+1].
  - If cur_idx == len-1 and loop = 1: cur_idx = 0, seq_out = table[0], wrap = 1 for one cycle; stay in RUN.
  - If cur_idx == len-1 and loop = 0: IDLE, done = 1 for one cycle, seq_valid = 0, seq_out holds the last code.
- RUN, start = 1: ignored; no restart.
- len = 1: every adv hits the last-entry rule (wrap each adv if looping, done on first adv if one-shot).
- Config writes:
  - Accepted only in IDLE; they take effect the next cycle.
  - cfg_we and len_we in the same cycle both apply.
  - A cfg_we or len_we in RUN is discarded and raises cfg_err for one cycle; the table and len are unchanged.
  - len_we with len_data = 0 or > DEPTH is discarded and raises cfg_err.
  - Config write and start in the same IDLE cycle: the write lands, and the sequence starts from pre-write contents for that cycle's table[0]. Benches must not rely on that value.
- done, wrap and cfg_err are single-cycle pulses, never stretched.
- Reset mid-RUN: immediate return to reset values; the table is reloaded with defaults.

Test Plan:
- Default sequence: release reset, start, then adv every cycle with loop = 0 -> seq_out 0,2,5,8,11,14; done pulses one cycle after the 14 is consumed; seq_valid drops; seq_out holds 14.
- Loop mode: loop = 1, start, 13 advs -> seq_out 0,2,5,8,11,14,0,2,5,8,11,14,0,2; wrap pulses exactly twice; done never asserts.
- Reprogram: in IDLE write table[0..2] = 3,9,15 and len = 3, one-shot run -> 3,9,15 then done.
- Illegal config: len_we with 0, len_we with 9, and cfg_we during RUN -> cfg_err pulses each time; later run still shows the original contents and length.
- Stop priority: in RUN at code 5, assert stop, adv and start together -> next cycle IDLE, busy = 0, seq_out = 5, no done.
- Async reset mid-run: drop rst_n between edges at code 8 -> outputs clear immediately; a subsequent start yields the default 0,2,5,... sequence.
